// File: rtl/ysyx_rob_pkg.sv
// rtl/ysyx_rob_pkg.sv - reorder buffer sizing, entry layout and tag helpers
package ysyx_rob_pkg;
   localparam int XLEN     = 32;
   localparam int ROB_SIZE = 8;
   localparam int IDX_W    = $clog2(ROB_SIZE);
   localparam int TAG_W    = IDX_W + 1;

   typedef struct packed {
      logic            valid;
      logic            done;
      logic [4:0]      rd;
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] pnpc;
      logic [31:0]     inst;
      logic [XLEN-1:0] result;
      logic [XLEN-1:0] npc;
      logic            trap;
      logic [XLEN-1:0] cause;
      logic [XLEN-1:0] tval;
   } rob_entry_t;

   // Tag 0 means "no producer", so slot i is published as tag i+1.
   function automatic logic [TAG_W-1:0] idx2tag(input logic [IDX_W-1:0] idx);
      return TAG_W'(idx) + TAG_W'(1);
   endfunction

   function automatic logic [IDX_W-1:0] tag2idx(input logic [TAG_W-1:0] tag);
      logic [TAG_W-1:0] t;
      t = tag - TAG_W'(1);
      return t[IDX_W-1:0];
   endfunction
endpackage

// File: rtl/ysyx_rob_rename.sv
// rtl/ysyx_rob_rename.sv - architectural register to in-flight producer tag table
module ysyx_rob_rename
   import ysyx_rob_pkg::*;
(
   input  logic             clock,
   input  logic             reset,
   input  logic [4:0]       rs1,
   input  logic [4:0]       rs2,
   output logic [TAG_W-1:0] tag1,
   output logic [TAG_W-1:0] tag2,
   input  logic             set_en,
   input  logic [4:0]       set_rd,
   input  logic [TAG_W-1:0] set_tag,
   input  logic             clr_en,
   input  logic [4:0]       clr_rd,
   input  logic [TAG_W-1:0] clr_tag,
   input  logic             flush
);
   logic [TAG_W-1:0] rtab [32];

   assign tag1 = rtab[rs1];
   assign tag2 = rtab[rs2];

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < 32; i++) rtab[i] <= '0;
      end else if (flush) begin
         for (int i = 0; i < 32; i++) rtab[i] <= '0;
      end else begin
         // A younger producer may already own the register; only drop our own mapping.
         if (clr_en && rtab[clr_rd] == clr_tag) rtab[clr_rd] <= '0;
         if (set_en && set_rd != 5'd0) rtab[set_rd] <= set_tag;
      end
   end
endmodule

// File: rtl/ysyx_rob.sv
// rtl/ysyx_rob.sv - circular reorder buffer with rename lookup and in-order commit
module ysyx_rob
   import ysyx_rob_pkg::*;
(
   input  logic             clock,
   input  logic             reset,
   input  logic             disp_valid,
   output logic             disp_ready,
   input  logic [4:0]       disp_rd,
   input  logic [4:0]       disp_rs1,
   input  logic [4:0]       disp_rs2,
   input  logic [XLEN-1:0]  disp_pc,
   input  logic [XLEN-1:0]  disp_pnpc,
   input  logic [31:0]      disp_inst,
   output logic [TAG_W-1:0] disp_dest,
   output logic [TAG_W-1:0] disp_qj,
   output logic [TAG_W-1:0] disp_qk,
   output logic [XLEN-1:0]  disp_vj,
   output logic [XLEN-1:0]  disp_vk,
   output logic             disp_fwdj,
   output logic             disp_fwdk,
   input  logic             exu_valid,
   input  logic [TAG_W-1:0] exu_dest,
   input  logic [XLEN-1:0]  exu_result,
   input  logic [XLEN-1:0]  exu_npc,
   input  logic             exu_trap,
   input  logic [XLEN-1:0]  exu_cause,
   input  logic [XLEN-1:0]  exu_tval,
   output logic             cmt_valid,
   output logic [4:0]       cmt_rd,
   output logic [XLEN-1:0]  cmt_wdata,
   output logic [XLEN-1:0]  cmt_pc,
   output logic [31:0]      cmt_inst,
   output logic             cmt_trap,
   output logic [XLEN-1:0]  cmt_cause,
   output logic [XLEN-1:0]  cmt_tval,
   output logic             flush_valid,
   output logic [XLEN-1:0]  flush_pc
);
   rob_entry_t       rob_q [ROB_SIZE];
   logic [IDX_W-1:0] head_q, tail_q;
   logic [TAG_W-1:0] count_q;
   logic [IDX_W-1:0] wb_idx;
   logic             wb_hit, disp_fire, commit, mispredict;
   rob_entry_t       head_e, wb_e, disp_e;
   logic [TAG_W-1:0] lk_tag [2];
   logic [4:0]       lk_rs  [2];
   logic [TAG_W-1:0] lk_q   [2];
   logic             lk_fwd [2];
   logic [XLEN-1:0]  lk_v   [2];

   assign disp_ready = (count_q < TAG_W'(ROB_SIZE)) & ~flush_valid;
   assign disp_fire  = disp_valid & disp_ready;
   assign disp_dest  = idx2tag(tail_q);
   assign wb_idx     = tag2idx(exu_dest);
   assign wb_hit     = exu_valid && exu_dest != '0 && exu_dest <= TAG_W'(ROB_SIZE)
                       && rob_q[wb_idx].valid;

   always_comb begin
      wb_e        = rob_q[wb_idx];
      wb_e.done   = 1'b1;
      wb_e.result = exu_result;
      wb_e.npc    = exu_npc;
      wb_e.trap   = exu_trap;
      wb_e.cause  = exu_cause;
      wb_e.tval   = exu_tval;
      disp_e       = '0;
      disp_e.valid = 1'b1;
      disp_e.rd    = disp_rd;
      disp_e.pc    = disp_pc;
      disp_e.pnpc  = disp_pnpc;
      disp_e.inst  = disp_inst;
   end

   // Head sees a same-cycle writeback so commit follows writeback by one cycle.
   always_comb begin
      head_e = rob_q[head_q];
      if (wb_hit && wb_idx == head_q) head_e = wb_e;
   end

   assign commit     = head_e.valid & head_e.done & ~flush_valid;
   assign mispredict = head_e.trap | (head_e.npc != head_e.pnpc);

   ysyx_rob_rename u_rename (
      .clock   (clock),
      .reset   (reset),
      .rs1     (disp_rs1),
      .rs2     (disp_rs2),
      .tag1    (lk_tag[0]),
      .tag2    (lk_tag[1]),
      .set_en  (disp_fire),
      .set_rd  (disp_rd),
      .set_tag (disp_dest),
      .clr_en  (commit),
      .clr_rd  (head_e.rd),
      .clr_tag (idx2tag(head_q)),
      .flush   (commit & mispredict)
   );

   assign lk_rs[0] = disp_rs1;
   assign lk_rs[1] = disp_rs2;

   always_comb begin
      for (int i = 0; i < 2; i++) begin
         lk_q[i]   = '0;
         lk_fwd[i] = 1'b0;
         lk_v[i]   = '0;
         if (lk_rs[i] != 5'd0 && lk_tag[i] != '0) begin
            if (rob_q[tag2idx(lk_tag[i])].done) begin
               lk_fwd[i] = 1'b1;
               lk_v[i]   = rob_q[tag2idx(lk_tag[i])].result;
            end else if (exu_valid && exu_dest == lk_tag[i]) begin
               lk_fwd[i] = 1'b1;
               lk_v[i]   = exu_result;
            end else begin
               lk_q[i]   = lk_tag[i];
            end
         end
      end
   end

   assign disp_qj   = lk_q[0];
   assign disp_qk   = lk_q[1];
   assign disp_fwdj = lk_fwd[0];
   assign disp_fwdk = lk_fwd[1];
   assign disp_vj   = lk_v[0];
   assign disp_vk   = lk_v[1];

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < ROB_SIZE; i++) rob_q[i] <= '0;
         head_q      <= '0;
         tail_q      <= '0;
         count_q     <= '0;
         cmt_valid   <= 1'b0;
         cmt_rd      <= '0;
         cmt_wdata   <= '0;
         cmt_pc      <= '0;
         cmt_inst    <= '0;
         cmt_trap    <= 1'b0;
         cmt_cause   <= '0;
         cmt_tval    <= '0;
         flush_valid <= 1'b0;
         flush_pc    <= '0;
      end else begin
         cmt_valid   <= commit;
         flush_valid <= commit & mispredict;
         if (commit) begin
            cmt_rd    <= head_e.trap ? 5'd0 : head_e.rd;
            cmt_wdata <= head_e.result;
            cmt_pc    <= head_e.pc;
            cmt_inst  <= head_e.inst;
            cmt_trap  <= head_e.trap;
            cmt_cause <= head_e.cause;
            cmt_tval  <= head_e.tval;
            flush_pc  <= head_e.npc;
         end
         // Squash at the committing edge; the flush cycle then sees an empty buffer.
         if (commit && mispredict) begin
            for (int i = 0; i < ROB_SIZE; i++) rob_q[i] <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
         end else begin
            if (wb_hit) rob_q[wb_idx] <= wb_e;
            if (disp_fire) rob_q[tail_q] <= disp_e;
            if (commit) rob_q[head_q] <= '0;
            head_q  <= head_q + IDX_W'(commit);
            tail_q  <= tail_q + IDX_W'(disp_fire);
            count_q <= count_q + TAG_W'(disp_fire) - TAG_W'(commit);
         end
      end
   end
endmodule

// File: tb/tb_ysyx_rob.sv
// tb/tb_ysyx_rob.sv - randomized and directed checks of ysyx_rob against a queue model
module tb_ysyx_rob;
   logic        clock, reset;
   logic        disp_valid;
   logic [4:0]  disp_rd, disp_rs1, disp_rs2;
   logic [31:0] disp_pc, disp_pnpc, disp_inst;
   logic        exu_valid, exu_trap;
   logic [3:0]  exu_dest;
   logic [31:0] exu_result, exu_npc, exu_cause, exu_tval;
   logic        disp_ready, disp_fwdj, disp_fwdk;
   logic [3:0]  disp_dest, disp_qj, disp_qk;
   logic [31:0] disp_vj, disp_vk;
   logic        cmt_valid, cmt_trap, flush_valid;
   logic [4:0]  cmt_rd;
   logic [31:0] cmt_wdata, cmt_pc, cmt_inst, cmt_cause, cmt_tval, flush_pc;

   ysyx_rob dut (
      .clock(clock), .reset(reset),
      .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_rd(disp_rd),
      .disp_rs1(disp_rs1), .disp_rs2(disp_rs2), .disp_pc(disp_pc),
      .disp_pnpc(disp_pnpc), .disp_inst(disp_inst), .disp_dest(disp_dest),
      .disp_qj(disp_qj), .disp_qk(disp_qk), .disp_vj(disp_vj), .disp_vk(disp_vk),
      .disp_fwdj(disp_fwdj), .disp_fwdk(disp_fwdk),
      .exu_valid(exu_valid), .exu_dest(exu_dest), .exu_result(exu_result),
      .exu_npc(exu_npc), .exu_trap(exu_trap), .exu_cause(exu_cause), .exu_tval(exu_tval),
      .cmt_valid(cmt_valid), .cmt_rd(cmt_rd), .cmt_wdata(cmt_wdata), .cmt_pc(cmt_pc),
      .cmt_inst(cmt_inst), .cmt_trap(cmt_trap), .cmt_cause(cmt_cause),
      .cmt_tval(cmt_tval), .flush_valid(flush_valid), .flush_pc(flush_pc)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct {
      int          tag;
      logic [4:0]  rd;
      logic [31:0] pc, pnpc, inst;
      bit          done;
      logic [31:0] result, npc;
      bit          trap;
      logic [31:0] cause, tval;
   } ment_t;

   ment_t       mq[$];
   int          m_tail;
   bit          m_flush, m_cmt;
   ment_t       m_last;
   int          n_vec, n_err;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
      end
   endtask

   // Youngest in-flight writer of rs decides availability.
   task automatic mlook(input logic [4:0] rs, output int q, output bit fwd, output logic [31:0] v);
      q = 0; fwd = 0; v = '0;
      if (rs == 5'd0) return;
      for (int i = mq.size() - 1; i >= 0; i--) begin
         if (mq[i].rd == rs) begin
            if (mq[i].done) begin fwd = 1; v = mq[i].result; end
            else if (exu_valid && int'(exu_dest) == mq[i].tag) begin fwd = 1; v = exu_result; end
            else q = mq[i].tag;
            return;
         end
      end
   endtask

   task automatic set_idle();
      disp_valid = 0; disp_rd = 0; disp_rs1 = 0; disp_rs2 = 0;
      disp_pc = 32'h8000_0000; disp_pnpc = 32'h8000_0004; disp_inst = 32'h13;
      exu_valid = 0; exu_dest = 0; exu_result = 0; exu_npc = 0;
      exu_trap = 0; exu_cause = 0; exu_tval = 0;
   endtask

   task automatic set_disp(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                           input logic [31:0] pc, input logic [31:0] pnpc);
      disp_valid = 1; disp_rd = rd; disp_rs1 = rs1; disp_rs2 = rs2;
      disp_pc = pc; disp_pnpc = pnpc; disp_inst = {pc[11:0], 20'h00093};
   endtask

   task automatic set_wb(input int tag, input logic [31:0] res, input logic [31:0] npc,
                         input bit trap, input logic [31:0] cause);
      exu_valid = 1; exu_dest = 4'(tag); exu_result = res; exu_npc = npc;
      exu_trap = trap; exu_cause = cause; exu_tval = res ^ 32'h5a5a_0000;
   endtask

   // Called just after a falling edge with stimulus applied; returns at the next falling edge.
   task automatic cycle();
      int          q;
      bit          fwd, exp_ready, fire, cmt, misp;
      logic [31:0] v;
      ment_t       he, ne;
      #1;
      exp_ready = (mq.size() < 8) && !m_flush;
      check("disp_ready", 32'(disp_ready), 32'(exp_ready));
      check("disp_dest", 32'(disp_dest), 32'(m_tail + 1));
      mlook(disp_rs1, q, fwd, v);
      check("disp_qj", 32'(disp_qj), 32'(q));
      check("disp_fwdj", 32'(disp_fwdj), 32'(fwd));
      if (fwd) check("disp_vj", disp_vj, v);
      mlook(disp_rs2, q, fwd, v);
      check("disp_qk", 32'(disp_qk), 32'(q));
      check("disp_fwdk", 32'(disp_fwdk), 32'(fwd));
      if (fwd) check("disp_vk", disp_vk, v);

      for (int i = 0; i < mq.size(); i++)
         if (exu_valid && !mq[i].done && mq[i].tag == int'(exu_dest)) begin
            mq[i].done = 1; mq[i].result = exu_result; mq[i].npc = exu_npc;
            mq[i].trap = exu_trap; mq[i].cause = exu_cause; mq[i].tval = exu_tval;
         end
      cmt = !m_flush && mq.size() > 0 && mq[0].done;
      he = cmt ? mq[0] : m_last;
      fire = disp_valid && exp_ready;
      if (fire) begin
         ne = '{tag: m_tail + 1, rd: disp_rd, pc: disp_pc, pnpc: disp_pnpc, inst: disp_inst,
                done: 0, result: 0, npc: 0, trap: 0, cause: 0, tval: 0};
         mq.push_back(ne);
         m_tail = (m_tail + 1) % 8;
      end
      misp = 0;
      if (cmt) begin
         void'(mq.pop_front());
         misp = he.trap || (he.npc != he.pnpc);
         if (misp) begin mq.delete(); m_tail = 0; end
         m_last = he;
      end
      m_cmt = cmt; m_flush = misp;

      @(posedge clock); @(negedge clock);
      check("cmt_valid", 32'(cmt_valid), 32'(m_cmt));
      check("flush_valid", 32'(flush_valid), 32'(m_flush));
      if (m_cmt) begin
         check("cmt_rd", 32'(cmt_rd), m_last.trap ? 32'd0 : 32'(m_last.rd));
         check("cmt_wdata", cmt_wdata, m_last.result);
         check("cmt_pc", cmt_pc, m_last.pc);
         check("cmt_inst", cmt_inst, m_last.inst);
         check("cmt_trap", 32'(cmt_trap), 32'(m_last.trap));
         check("cmt_cause", cmt_cause, m_last.cause);
         check("cmt_tval", cmt_tval, m_last.tval);
      end
      if (m_flush) check("flush_pc", flush_pc, m_last.npc);
      set_idle();
   endtask

   task automatic model_clear();
      mq.delete(); m_tail = 0; m_flush = 0; m_cmt = 0;
   endtask

   task automatic do_reset();
      set_idle();
      reset = 0;
      repeat (2) @(negedge clock);
      reset = 1;
      model_clear();
      #1;
      check("rst_cmt_valid", 32'(cmt_valid), 32'd0);
      check("rst_cmt_rd", 32'(cmt_rd), 32'd0);
      check("rst_cmt_wdata", cmt_wdata, 32'd0);
      check("rst_flush", 32'(flush_valid), 32'd0);
      check("rst_ready", 32'(disp_ready), 32'd1);
      check("rst_dest", 32'(disp_dest), 32'd1);
   endtask

   task automatic random_cycle();
      int pick[$];
      int r;
      logic [31:0] pc;
      set_idle();
      if ($urandom_range(0, 99) < 60) begin
         pc = 32'h8000_0000 + ($urandom_range(0, 4095) << 2);
         set_disp(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                  5'($urandom_range(0, 7)), pc, pc + 4);
      end
      foreach (mq[i]) if (!mq[i].done) pick.push_back(i);
      r = $urandom_range(0, 99);
      if (r < 50 && pick.size() > 0) begin
         ment_t e;
         e = mq[pick[$urandom_range(0, pick.size() - 1)]];
         set_wb(e.tag, $urandom(), ($urandom_range(0, 99) < 5) ? e.pnpc + 32'h100 : e.pnpc,
                $urandom_range(0, 99) < 3, 32'($urandom_range(0, 11)));
      end else if (r < 55 && mq.size() < 8) begin
         int t;
         t = 0;
         for (int c = 1; c <= 8 && t == 0; c++) begin
            bit used;
            used = 0;
            foreach (mq[i]) if (mq[i].tag == c) used = 1;
            if (!used) t = c;
         end
         set_wb(t, $urandom(), 32'h0, 1'b0, 32'h0);
      end
      #0;
      cycle();
   endtask

   initial begin
      n_vec = 0; n_err = 0;
      m_last = '{tag: 0, rd: 0, pc: 0, pnpc: 0, inst: 0, done: 0, result: 0,
                 npc: 0, trap: 0, cause: 0, tval: 0};
      set_idle();
      reset = 0;
      @(negedge clock);
      do_reset();

      // Simple addi commit
      set_disp(5'd1, 5'd0, 5'd0, 32'h8000_0000, 32'h8000_0004);
      #1 check("addi_dest", 32'(disp_dest), 32'd1);
      cycle();
      set_wb(1, 32'd5, 32'h8000_0004, 0, 0);
      cycle();
      check("addi_cmt_wdata", cmt_wdata, 32'd5);

      // Dependency tracking and same-cycle writeback bypass
      do_reset();
      set_disp(5'd1, 5'd0, 5'd0, 32'h8000_0000, 32'h8000_0004); cycle();
      set_disp(5'd2, 5'd1, 5'd0, 32'h8000_0004, 32'h8000_0008);
      #1 check("dep_qj", 32'(disp_qj), 32'd1);
      cycle();
      set_disp(5'd3, 5'd1, 5'd1, 32'h8000_0008, 32'h8000_000c);
      set_wb(1, 32'd7, 32'h8000_0004, 0, 0);
      #1 check("byp_vj", disp_vj, 32'd7);
      cycle();

      // Fill, reverse-order writeback, in-order drain, wrap
      do_reset();
      for (int i = 0; i < 8; i++) begin
         set_disp(5'(i + 1), 5'(i), 5'd0, 32'h8000_0000 + 32'(i * 4), 32'h8000_0004 + 32'(i * 4));
         cycle();
      end
      set_disp(5'd9, 5'd0, 5'd0, 32'h8000_0020, 32'h8000_0024);
      #1 check("full_ready", 32'(disp_ready), 32'd0);
      cycle();
      for (int t = 8; t >= 1; t--) begin
         set_wb(t, 32'(t * 11), 32'h8000_0000 + 32'(t * 4), 0, 0);
         cycle();
      end
      repeat (8) begin set_idle(); cycle(); end
      set_disp(5'd4, 5'd0, 5'd0, 32'h8000_0100, 32'h8000_0104);
      #1 check("wrap_dest", 32'(disp_dest), 32'd1);
      cycle();

      // Mispredict squashes younger completed work
      do_reset();
      set_disp(5'd1, 5'd0, 5'd0, 32'h8000_0000, 32'h8000_0004); cycle();
      for (int i = 1; i < 4; i++) begin
         set_disp(5'(i + 1), 5'd1, 5'd0, 32'h8000_0000 + 32'(i * 4), 32'h8000_0004 + 32'(i * 4));
         cycle();
      end
      for (int t = 2; t <= 4; t++) begin
         set_wb(t, 32'(t), 32'h8000_0000 + 32'(t * 4), 0, 0); cycle();
      end
      set_wb(1, 32'd1, 32'h8000_0100, 0, 0); cycle();
      check("misp_flush_pc", flush_pc, 32'h8000_0100);
      repeat (3) begin set_idle(); cycle(); end

      // Trap suppresses writeback and flushes
      do_reset();
      set_disp(5'd5, 5'd0, 5'd0, 32'h8000_0000, 32'h8000_0004); cycle();
      set_wb(1, 32'd9, 32'h8000_0004, 1, 32'd2); cycle();
      check("trap_cause", cmt_cause, 32'd2);
      set_idle(); cycle();

      // Asynchronous reset with work in flight
      do_reset();
      for (int i = 0; i < 4; i++) begin
         set_disp(5'(i + 1), 5'd0, 5'd0, 32'h8000_0000 + 32'(i * 4), 32'h8000_0004 + 32'(i * 4));
         cycle();
      end
      set_wb(1, 32'd3, 32'h8000_0004, 0, 0); cycle();
      #2 reset = 0;
      #1 check("async_cmt_valid", 32'(cmt_valid), 32'd0);
      check("async_ready", 32'(disp_ready), 32'd1);
      @(negedge clock);
      do_reset();

      for (int n = 0; n < 3000; n++) begin
         if ($urandom_range(0, 599) == 0) do_reset();
         random_cycle();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
